// File: rtl/support_seq.sv
`timescale 1ns/1ps
// support_seq: button debouncer with press/release/long-press events and a
// timed DCM-reset -> CPU-reset -> boot sequencer with warm/cold restart.
module support_seq #(
  parameter int NBTN         = 2,
  parameter int TICK_DIV     = 1024,
  parameter int DEBOUNCE     = 10,
  parameter int LONG_TICKS   = 2000,
  parameter int DCM_LEN      = 10,
  parameter int WAIT_LEN     = 4,
  parameter int RST_LEN      = 40,
  parameter int BOOT_OVERLAP = 10,
  parameter int BOOT_LEN     = 8
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn,
  output logic            dcm_reset,
  output logic            cpu_reset,
  output logic            boot,
  output logic            interrupt,
  output logic [NBTN-1:0] btn_state,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long,
  output logic            seq_busy
);

  localparam int PW      = $clog2(TICK_DIV);
  localparam int DW      = $clog2(DEBOUNCE);
  localparam int HW      = $clog2(LONG_TICKS + 1);
  localparam int MAX_A   = (DCM_LEN > WAIT_LEN) ? DCM_LEN : WAIT_LEN;
  localparam int MAX_B   = (RST_LEN > BOOT_LEN) ? RST_LEN : BOOT_LEN;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_DCM   = 3'd0,
    S_WAIT  = 3'd1,
    S_RESET = 3'd2,
    S_BOOT  = 3'd3,
    S_RUN   = 3'd4
  } seq_state_e;

  // ---------------- button path ----------------
  logic [NBTN-1:0] sync1_q, sync1_d;
  logic [NBTN-1:0] sync2_q, sync2_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_s;
  logic [DW-1:0]   dcnt_q [NBTN];
  logic [DW-1:0]   dcnt_d [NBTN];
  logic [HW-1:0]   hold_q [NBTN];
  logic [HW-1:0]   hold_d [NBTN];
  logic [NBTN-1:0] btn_state_q, btn_state_d;
  logic [NBTN-1:0] btn_press_q, btn_press_d;
  logic [NBTN-1:0] btn_release_q, btn_release_d;
  logic [NBTN-1:0] btn_long_q, btn_long_d;

  // Two-flop synchroniser feeding the debouncers.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  // Shared prescaler: sample tick once every TICK_DIV cycles.
  always_comb begin
    tick_s = (presc_q == PW'(TICK_DIV - 1));
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Per-channel debounce flip with edge events, plus the long-press hold counter.
  always_comb begin
    btn_state_d   = btn_state_q;
    btn_press_d   = {NBTN{1'b0}};
    btn_release_d = {NBTN{1'b0}};
    btn_long_d    = {NBTN{1'b0}};
    for (int i = 0; i < NBTN; i++) begin
      dcnt_d[i] = dcnt_q[i];
      hold_d[i] = hold_q[i];
      if (!tick_s) begin
        dcnt_d[i] = dcnt_q[i];
      end else if (sync2_q[i] == btn_state_q[i]) begin
        dcnt_d[i] = {DW{1'b0}};
      end else if (dcnt_q[i] == DW'(DEBOUNCE - 1)) begin
        // DEBOUNCE-th consecutive disagreeing sample: accept the new level.
        dcnt_d[i]        = {DW{1'b0}};
        btn_state_d[i]   = sync2_q[i];
        btn_press_d[i]   = sync2_q[i];
        btn_release_d[i] = ~sync2_q[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
      // Hold counter saturates at LONG_TICKS so the long event fires once per hold.
      if (!btn_state_q[i]) begin
        hold_d[i] = {HW{1'b0}};
      end else if (tick_s && (hold_q[i] != HW'(LONG_TICKS))) begin
        hold_d[i]     = hold_q[i] + 1'b1;
        btn_long_d[i] = (hold_q[i] == HW'(LONG_TICKS - 1));
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  // Button-path registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q       <= {NBTN{1'b0}};
      sync2_q       <= {NBTN{1'b0}};
      presc_q       <= {PW{1'b0}};
      btn_state_q   <= {NBTN{1'b0}};
      btn_press_q   <= {NBTN{1'b0}};
      btn_release_q <= {NBTN{1'b0}};
      btn_long_q    <= {NBTN{1'b0}};
      for (int i = 0; i < NBTN; i++) begin
        dcnt_q[i] <= {DW{1'b0}};
        hold_q[i] <= {HW{1'b0}};
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      presc_q       <= presc_d;
      btn_state_q   <= btn_state_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      btn_long_q    <= btn_long_d;
      for (int i = 0; i < NBTN; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  // ---------------- sequencer ----------------
  seq_state_e    state_q, state_d, adv_state_s;
  logic [CW-1:0] cnt_q, cnt_d, adv_cnt_s;
  logic          dcm_reset_q, dcm_reset_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          boot_q, boot_d;
  logic          seq_busy_q, seq_busy_d;
  logic          interrupt_q, interrupt_d;
  logic          press1_s;

  generate
    if (NBTN >= 2) begin : g_irq_src
      assign press1_s = btn_press_q[1];
    end else begin : g_no_irq_src
      assign press1_s = 1'b0;
    end
  endgenerate

  // Next state: timed advance, then restart overrides; outputs decoded from next state.
  always_comb begin
    adv_state_s = state_q;
    adv_cnt_s   = cnt_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_DCM: begin
        if (cnt_q == {CW{1'b0}}) begin
          adv_state_s = S_WAIT;
          adv_cnt_s   = CW'(WAIT_LEN - 1);
        end else begin
          adv_cnt_s = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          adv_state_s = S_RESET;
          adv_cnt_s   = CW'(RST_LEN - 1);
        end else begin
          adv_cnt_s = cnt_q - 1'b1;
        end
      end
      S_RESET: begin
        if (cnt_q == {CW{1'b0}}) begin
          adv_state_s = S_BOOT;
          adv_cnt_s   = CW'(BOOT_LEN - 1);
        end else begin
          adv_cnt_s = cnt_q - 1'b1;
        end
      end
      S_BOOT: begin
        if (cnt_q == {CW{1'b0}}) begin
          adv_state_s = S_RUN;
          adv_cnt_s   = {CW{1'b0}};
        end else begin
          adv_cnt_s = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        adv_state_s = S_RUN;
        adv_cnt_s   = {CW{1'b0}};
      end
      default: begin
        adv_state_s = S_DCM;
        adv_cnt_s   = CW'(DCM_LEN - 1);
      end
    endcase

    // Cold restart beats warm restart; warm restart only from S_RUN.
    if (btn_long_q[0]) begin
      state_d = S_DCM;
      cnt_d   = CW'(DCM_LEN - 1);
    end else if (btn_press_q[0] && (state_q == S_RUN)) begin
      state_d = S_RESET;
      cnt_d   = CW'(RST_LEN - 1);
    end else begin
      state_d = adv_state_s;
      cnt_d   = adv_cnt_s;
    end

    dcm_reset_d = (state_d == S_DCM);
    cpu_reset_d = (state_d == S_DCM) || (state_d == S_WAIT) || (state_d == S_RESET);
    boot_d      = ((state_d == S_RESET) && (cnt_d < CW'(BOOT_OVERLAP))) || (state_d == S_BOOT);
    seq_busy_d  = (state_d != S_RUN);
    interrupt_d = press1_s && (state_q == S_RUN);
  end

  // Sequencer state and registered sequence outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_DCM;
      cnt_q       <= CW'(DCM_LEN - 1);
      dcm_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      boot_q      <= 1'b0;
      seq_busy_q  <= 1'b1;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcm_reset_q <= dcm_reset_d;
      cpu_reset_q <= cpu_reset_d;
      boot_q      <= boot_d;
      seq_busy_q  <= seq_busy_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign dcm_reset   = dcm_reset_q;
  assign cpu_reset   = cpu_reset_q;
  assign boot        = boot_q;
  assign seq_busy    = seq_busy_q;
  assign interrupt   = interrupt_q;
  assign btn_state   = btn_state_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;
  assign btn_long    = btn_long_q;

endmodule

// File: tb/tb_support_seq.sv
`timescale 1ns/1ps
// tb_support_seq: directed checks of power-on timing, debounce, warm/cold
// restart, interrupt gating and asynchronous reset mid-sequence.
module tb_support_seq;

  logic       sysclk;
  logic       reset;
  logic [1:0] btn;
  logic       dcm_reset, cpu_reset, boot, interrupt, seq_busy;
  logic [1:0] btn_state, btn_press, btn_release, btn_long;

  int n_checks;
  int n_errors;
  int cyc;
  int n_press[2];
  int n_rel[2];
  int n_long[2];
  int n_int;
  int press_cyc[2];
  int long_cyc[2];
  int int_cyc;
  int g0;
  int b_press0, b_press1, b_rel0, b_rel1, b_long0, b_long1, b_int;

  support_seq #(
    .NBTN(2), .TICK_DIV(4), .DEBOUNCE(3), .LONG_TICKS(8), .DCM_LEN(10),
    .WAIT_LEN(4), .RST_LEN(40), .BOOT_OVERLAP(10), .BOOT_LEN(8)
  ) dut (
    .sysclk(sysclk), .reset(reset), .btn(btn),
    .dcm_reset(dcm_reset), .cpu_reset(cpu_reset), .boot(boot),
    .interrupt(interrupt), .btn_state(btn_state), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long), .seq_busy(seq_busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Event tally sampled on the active edge (values of the cycle just ending).
  always @(posedge sysclk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (btn_press[i]) begin
          n_press[i]   <= n_press[i] + 1;
          press_cyc[i] <= cyc;
        end
        if (btn_release[i]) n_rel[i] <= n_rel[i] + 1;
        if (btn_long[i]) begin
          n_long[i]   <= n_long[i] + 1;
          long_cyc[i] <= cyc;
        end
      end
      if (interrupt) begin
        n_int   <= n_int + 1;
        int_cyc <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sysclk);
    cyc++;
  endtask

  task automatic align2();
    while (cyc % 4 != 2) step();
  endtask

  task automatic snap();
    b_press0 = n_press[0]; b_press1 = n_press[1];
    b_rel0   = n_rel[0];   b_rel1   = n_rel[1];
    b_long0  = n_long[0];  b_long1  = n_long[1];
    b_int    = n_int;
  endtask

  // {dcm_reset, cpu_reset, boot, seq_busy, interrupt} at cycle s of a sequence;
  // a warm sequence starts at S_RESET, i.e. 14 cycles into the full timeline.
  function automatic logic [4:0] exp_seq(input bit cold, input int s);
    int t;
    t = cold ? s : s + 14;
    return {cold && (s <= 9), (t <= 53), (t >= 44) && (t <= 61), (t <= 61), 1'b0};
  endfunction

  task automatic check_seq(input string tag, input bit cold, input int n);
    for (int s = 0; s < n; s++) begin
      check_eq($sformatf("%s_c%0d", tag, s),
               int'({dcm_reset, cpu_reset, boot, seq_busy, interrupt}),
               int'(exp_seq(cold, s)));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset    = 1'b0;
    btn      = 2'b00;
    #1 reset = 1'b1;
    repeat (3) @(negedge sysclk);

    // Reset values
    check_eq("rst_outs", int'({dcm_reset, cpu_reset, boot, seq_busy, interrupt}), 5'b11010);
    check_eq("rst_btn",  int'({btn_state, btn_press, btn_release, btn_long}), 0);

    // Power-on timeline
    reset = 1'b0;
    cyc   = 0;
    snap();
    check_seq("pwr", 1'b1, 70);
    check_eq("pwr_events", n_press[0] + n_press[1] + n_rel[0] + n_rel[1]
                           + n_long[0] + n_long[1] + n_int, 0);

    // Debounce of btn[1]: three ticks, one press, one interrupt
    align2();
    g0 = cyc;
    snap();
    btn[1] = 1'b1;
    repeat (13) step();
    check_eq("db_before", int'(btn_state[1]), 0);
    step();
    check_eq("db_state", int'(btn_state[1]), 1);
    check_eq("db_press", int'(btn_press[1]), 1);
    step();
    check_eq("db_press_once", int'(btn_press[1]), 0);
    check_eq("db_irq", int'(interrupt), 1);
    step();
    check_eq("db_irq_once", int'(interrupt), 0);
    repeat (4) step();
    check_eq("db_npress", n_press[1] - b_press1, 1);
    check_eq("db_nirq", n_int - b_int, 1);
    check_eq("db_irq_cyc", int_cyc - g0, 15);

    // Short 0-glitches must not release
    for (int k = 0; k < 3; k++) begin
      btn[1] = 1'b0;
      repeat (1 + 3 * k) step();
      btn[1] = 1'b1;
      repeat (20) step();
    end
    check_eq("glitch_norel", n_rel[1] - b_rel1, 0);
    check_eq("glitch_state", int'(btn_state[1]), 1);
    check_eq("long1_once", n_long[1] - b_long1, 1);
    check_eq("long1_cyc", long_cyc[1] - g0, 46);
    btn[1] = 1'b0;
    repeat (20) step();
    check_eq("db_rel", n_rel[1] - b_rel1, 1);
    check_eq("db_rel_state", int'(btn_state[1]), 0);

    // Warm restart; second press of btn[0] and a btn[1] press during S_RESET
    align2();
    g0 = cyc;
    snap();
    btn[0] = 1'b1;
    fork
      begin
        repeat (20) @(negedge sysclk);
        btn[0] = 1'b0;
        repeat (19) @(negedge sysclk);
        btn = 2'b11;
        repeat (20) @(negedge sysclk);
        btn = 2'b00;
      end
    join_none
    repeat (14) step();
    check_eq("warm_press", int'(btn_press[0]), 1);
    step();
    check_seq("warm", 1'b0, 56);
    check_eq("warm_npress0", n_press[0] - b_press0, 2);
    check_eq("warm_press2_cyc", press_cyc[0] - g0, 50);
    check_eq("gate_press1", n_press[1] - b_press1, 1);
    check_eq("gate_press1_cyc", press_cyc[1] - g0, 50);
    check_eq("gate_noirq", n_int - b_int, 0);
    check_eq("warm_nolong", n_long[0] - b_long0, 0);
    check_eq("warm_nrel", n_rel[0] - b_rel0, 2);

    // Cold restart: press then long press while held
    align2();
    g0 = cyc;
    snap();
    btn[0] = 1'b1;
    fork
      begin
        repeat (60) @(negedge sysclk);
        btn[0] = 1'b0;
      end
    join_none
    repeat (14) step();
    check_eq("cold_press", int'(btn_press[0]), 1);
    step();
    check_seq("cold_warm", 1'b0, 32);
    check_seq("cold", 1'b1, 70);
    check_eq("cold_nlong", n_long[0] - b_long0, 1);
    check_eq("cold_long_cyc", long_cyc[0] - g0, 46);
    check_eq("cold_npress", n_press[0] - b_press0, 1);
    check_eq("cold_nrel", n_rel[0] - b_rel0, 1);

    // Power-on with btn[1] held, then async reset while in S_BOOT
    btn[1] = 1'b1;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
    snap();
    check_seq("pre_boot", 1'b1, 58);
    check_eq("pre_rst_state1", int'(btn_state[1]), 1);
    check_eq("pre_rst_press1", n_press[1] - b_press1, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("async_outs", int'({dcm_reset, cpu_reset, boot, seq_busy, interrupt}), 5'b11010);
    check_eq("async_btn", int'({btn_state, btn_press, btn_release, btn_long}), 0);
    btn = 2'b00;
    @(negedge sysclk);
    reset = 1'b0;
    cyc   = 0;
    snap();
    check_seq("repeat", 1'b1, 70);
    check_eq("repeat_events", (n_press[0] - b_press0) + (n_press[1] - b_press1)
                              + (n_rel[0] - b_rel0) + (n_rel[1] - b_rel1)
                              + (n_long[0] - b_long0) + (n_long[1] - b_long1)
                              + (n_int - b_int), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
